// File: rtl/sram_controller.sv
// MEM-stage controller: one 32-bit word access done as two 16-bit accesses on an async SRAM.
// Optional SRAM_CTRL_ADDR_CHECK_EN: out-of-range requests finish at once with no SRAM activity.
module sram_controller #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] MEM_Result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LO     = 2'd1;
  localparam logic [1:0]  ST_HI     = 2'd2;
  localparam logic [1:0]  ST_DONE   = 2'd3;
  localparam logic [3:0]  CNT_LAST  = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] DATA_BASE = 32'd1024;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] res_lo_q, res_lo_d;
  logic [31:0] mem_result_q, mem_result_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;

  logic [31:0] off_s;
  logic        req_s;
  logic        last_s;
  logic        out_of_range_s;
  logic        unused_off_s;

  assign off_s        = address - DATA_BASE;
  assign req_s        = MEMread | MEMwrite;
  assign last_s       = (cnt_q == CNT_LAST);
  assign unused_off_s = ^{off_s[31:19], off_s[1:0]};

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  // Below the base the subtraction wraps, so one test on the high bits covers both ends.
  assign out_of_range_s = |off_s[31:19];
`else
  assign out_of_range_s = 1'b0;
`endif

  // Next-state logic, transfer latching, and registered SRAM bus outputs derived from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    res_lo_d     = res_lo_q;
    mem_result_d = mem_result_q;
    sram_addr_d  = sram_addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = 1'b0;
    we_n_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          is_write_d = MEMwrite;
          word_d     = off_s[18:2];
          wdata_d    = data;
          cnt_d      = 4'd0;
          if (out_of_range_s) begin
            state_d = ST_DONE;
            if (!MEMwrite) begin
              mem_result_d = 32'd0;
            end else begin
              mem_result_d = mem_result_q;
            end
          end else begin
            state_d = ST_LO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (last_s) begin
          state_d = ST_HI;
          cnt_d   = 4'd0;
          if (!is_write_q) begin
            res_lo_d = sram_dq_in;
          end else begin
            res_lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HI: begin
        if (last_s) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          if (!is_write_q) begin
            mem_result_d = {sram_dq_in, res_lo_q};
          end else begin
            mem_result_d = mem_result_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // we_n rises on the last cycle of each half so data is held across the write edge.
    if ((state_d == ST_LO) || (state_d == ST_HI)) begin
      sram_addr_d = {word_d, (state_d == ST_HI)};
      dq_out_d    = (state_d == ST_HI) ? wdata_d[31:16] : wdata_d[15:0];
      dq_oe_d     = is_write_d;
      we_n_d      = ~(is_write_d && (cnt_d != CNT_LAST));
    end else begin
      dq_oe_d = 1'b0;
      we_n_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      is_write_q   <= 1'b0;
      word_q       <= 17'd0;
      wdata_q      <= 32'd0;
      res_lo_q     <= 16'd0;
      mem_result_q <= 32'd0;
      sram_addr_q  <= 18'd0;
      dq_out_q     <= 16'd0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      res_lo_q     <= res_lo_d;
      mem_result_q <= mem_result_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
    end
  end

  assign ready       = ((state_q == ST_IDLE) && !req_s) || (state_q == ST_DONE);
  assign MEM_Result  = mem_result_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (ACCESS_CYCLES=2) with a behavioural async SRAM.
// Honours SRAM_CTRL_ADDR_CHECK_EN for the out-of-range case.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMread;
  logic        MEMwrite;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] MEM_Result;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] mem [0:262143];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  we_log;
  logic [7:0]  oe_log;
  logic [7:0]  rdy_log;
  logic [17:0] addr_log [8];
  logic [15:0] dq_log [8];

  int          rc1, rc2, ra1, ra2;
  logic [31:0] res;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write while we_n low, combinational read.
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr];

  sram_controller #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite),
    .address(address), .data(data), .MEM_Result(MEM_Result), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the transfer.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int rcyc, output int rabs, output logic [31:0] r);
    MEMread  = rd;
    MEMwrite = wr;
    address  = a;
    data     = d;
    rcyc     = -1;
    rabs     = -1;
    r        = 32'hxxxx_xxxx;
    we_log   = 8'hFF;
    oe_log   = 8'h00;
    rdy_log  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      addr_log[i] = 18'd0;
      dq_log[i]   = 16'd0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      we_log[c]   = sram_we_n;
      oe_log[c]   = sram_dq_oe;
      rdy_log[c]  = ready;
      addr_log[c] = sram_addr;
      dq_log[c]   = sram_dq_out;
      if (ready) begin
        rcyc = c;
        rabs = cyc;
        r    = MEM_Result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    MEMread  = 1'b0;
    MEMwrite = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    MEMread  = 1'b1;
    MEMwrite = 1'b0;
    address  = 32'd1032;
    data     = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_result", MEM_Result, 32'd0);
    check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check_eq("rst_addr", {14'd0, sram_addr}, 32'd0);

    // Let the read reach HI, then reset it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("hi_addr", {14'd0, sram_addr}, 32'd5);
    rst     = 1'b1;
    MEMread = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    check_eq("abort_result", MEM_Result, 32'd0);
    check_eq("abort_addr", {14'd0, sram_addr}, 32'd0);
    check_eq("abort_we_n", {31'd0, sram_we_n}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_ready", {31'd0, ready}, 32'd1);
    end
    @(posedge clk); #1;

    xfer(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, rc1, ra1, res);
    check_eq("wr_ready_cyc", rc1, 32'd5);
    check_eq("wr_we_n", {26'd0, we_log[5:0]}, 32'b110101);
    check_eq("wr_oe", {26'd0, oe_log[5:0]}, 32'b011110);
    check_eq("wr_addr_lo", {14'd0, addr_log[1]}, 32'd4);
    check_eq("wr_dq_lo", {16'd0, dq_log[1]}, 32'h0000BEEF);
    check_eq("wr_addr_hi", {14'd0, addr_log[3]}, 32'd5);
    check_eq("wr_dq_hi", {16'd0, dq_log[3]}, 32'h0000DEAD);
    check_eq("wr_mem4", {16'd0, mem[4]}, 32'h0000BEEF);
    check_eq("wr_mem5", {16'd0, mem[5]}, 32'h0000DEAD);

    xfer(1'b1, 1'b0, 32'd1032, 32'd0, rc1, ra1, res);
    check_eq("rd_ready_cyc", rc1, 32'd5);
    check_eq("rd_ready_low", {27'd0, rdy_log[4:0]}, 32'd0);
    check_eq("rd_oe", {26'd0, oe_log[5:0]}, 32'd0);
    check_eq("rd_result", res, 32'hDEADBEEF);

    xfer(1'b1, 1'b0, 32'd1035, 32'd0, rc1, ra1, res);
    check_eq("rd_unaligned", res, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("rd_hold", MEM_Result, 32'hDEADBEEF);
    @(posedge clk); #1;

    xfer(1'b1, 1'b1, 32'd1024, 32'h12345678, rc1, ra1, res);
    check_eq("both_ready_cyc", rc1, 32'd5);
    check_eq("both_result_kept", res, 32'hDEADBEEF);
    check_eq("both_we_n", {26'd0, we_log[5:0]}, 32'b110101);
    check_eq("both_mem0", {16'd0, mem[0]}, 32'h00005678);
    check_eq("both_mem1", {16'd0, mem[1]}, 32'h00001234);

    xfer(1'b1, 1'b0, 32'd1024, 32'd0, rc1, ra1, res);
    check_eq("rd1024", res, 32'h12345678);

    xfer(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, rc1, ra1, res);
    xfer(1'b1, 1'b0, 32'd1040, 32'd0, rc2, ra2, res);
    check_eq("b2b_gap", ra2 - ra1, 32'd6);
    check_eq("b2b_result", res, 32'hCAFEF00D);
    check_eq("b2b_addr", {14'd0, addr_log[1]}, 32'd8);

    xfer(1'b1, 1'b0, 32'd512, 32'd0, rc1, ra1, res);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    check_eq("oor_ready_cyc", rc1, 32'd1);
    check_eq("oor_result", res, 32'd0);
    check_eq("oor_we_n", {30'd0, we_log[1:0]}, 32'b11);
`else
    check_eq("oor_ready_cyc", rc1, 32'd5);
    check_eq("oor_addr_lo", {14'd0, addr_log[1]}, 32'h0003FF00);
    check_eq("oor_addr_hi", {14'd0, addr_log[3]}, 32'h0003FF01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
